// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, with a one-entry skid buffer and redirect handling.
// Optional feature macro: BRANCH_DELAY_SLOT_EN (delay-slot branches instead of flush/squash).
module if_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_WORD = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc_out,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  input  logic        mem_conflict,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc,
  output logic        ifid_valid,
  output logic        fetch_hold
);

  localparam int unsigned XLEN = 16;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   skid_instr_q, skid_instr_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic [XLEN-1:0]   ifid_instr_q, ifid_instr_d;
  logic [XLEN-1:0]   ifid_pc_q, ifid_pc_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic              squash_q, squash_d;
  logic              pending_q, pending_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              fetch_hold_q;

  logic              accept;
  logic              flush;
  logic [XLEN-1:0]   pc_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      pc_q         <= RESET_PC;
      skid_instr_q <= NOP_WORD;
      skid_pc_q    <= XLEN'(0);
      ifid_instr_q <= NOP_WORD;
      ifid_pc_q    <= XLEN'(0);
      ifid_valid_q <= 1'b0;
      squash_q     <= 1'b0;
      pending_q    <= 1'b0;
      target_q     <= XLEN'(0);
      fetch_hold_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_valid_q <= ifid_valid_d;
      squash_q     <= squash_d;
      pending_q    <= pending_d;
      target_q     <= target_d;
      fetch_hold_q <= (state_d == S_FULL);
    end
  end

  // Next-state: redirect, drain, accept and bubble insertion
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_valid_d = ifid_valid_q;
    squash_d     = squash_q;
    pending_d    = pending_q;
    target_d     = target_q;

    accept = instr_valid && !mem_conflict && !squash_q;

`ifdef BRANCH_DELAY_SLOT_EN
    flush   = 1'b0;
    pc_next = pending_q ? target_q : XLEN'(pc_q + XLEN'(1));
`else
    flush   = branch_taken;
    pc_next = XLEN'(pc_q + XLEN'(1));
`endif

    // A returning word after a flush belongs to the old path
    if (instr_valid && squash_q) squash_d = 1'b0;

    if (flush) begin
      pc_d         = branch_target;
      ifid_instr_d = NOP_WORD;
      ifid_valid_d = 1'b0;
      state_d      = S_EMPTY;
      squash_d     = !instr_valid;
    end else if (!stall) begin
      if (state_q == S_FULL) begin
        ifid_instr_d = skid_instr_q;
        ifid_pc_d    = skid_pc_q;
        ifid_valid_d = 1'b1;
        if (accept) begin
          skid_instr_d = instr_in;
          skid_pc_d    = pc_q;
          pc_d         = pc_next;
          pending_d    = 1'b0;
        end else begin
          state_d = S_EMPTY;
        end
      end else if (accept) begin
        ifid_instr_d = instr_in;
        ifid_pc_d    = pc_q;
        ifid_valid_d = 1'b1;
        pc_d         = pc_next;
        pending_d    = 1'b0;
      end else begin
        ifid_instr_d = NOP_WORD;
        ifid_valid_d = 1'b0;
      end
    end else if (state_q == S_EMPTY && accept) begin
      skid_instr_d = instr_in;
      skid_pc_d    = pc_q;
      pc_d         = pc_next;
      pending_d    = 1'b0;
      state_d      = S_FULL;
    end

`ifdef BRANCH_DELAY_SLOT_EN
    // A newer branch overrides any target still waiting for its delay slot
    if (branch_taken) begin
      pending_d = 1'b1;
      target_d  = branch_target;
    end
`endif
  end

  assign pc_out     = pc_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_valid = ifid_valid_q;
  assign fetch_hold = fetch_hold_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Table-driven bench for if_fetch_stage; per-cycle expectations flow through a scoreboard queue.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_out;
  logic [15:0] instr_in = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        mem_conflict = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
  logic        fetch_hold;

  int total = 0;
  int bad   = 0;

  if_fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .pc_out       (pc_out),
    .instr_in     (instr_in),
    .instr_valid  (instr_valid),
    .mem_conflict (mem_conflict),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_valid   (ifid_valid),
    .fetch_hold   (fetch_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, iv, mc, st, br;
    logic [15:0] instr, tgt;
    logic [15:0] e_instr, e_pc;
    logic        e_valid;
    logic [15:0] e_pcout;
    logic        e_hold;
  } vec_t;

  typedef struct {
    int          row;
    logic [15:0] e_instr, e_pc;
    logic        e_valid;
    logic [15:0] e_pcout;
    logic        e_hold;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic void add(input logic r, input logic iv, input logic mc, input logic st,
                              input logic br, input logic [15:0] ins, input logic [15:0] tgt,
                              input logic [15:0] ei, input logic [15:0] ep, input logic ev,
                              input logic [15:0] epc, input logic eh);
    vec_t v;
    v.rst = r; v.iv = iv; v.mc = mc; v.st = st; v.br = br; v.instr = ins; v.tgt = tgt;
    v.e_instr = ei; v.e_pc = ep; v.e_valid = ev; v.e_pcout = epc; v.e_hold = eh;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  task automatic run_vectors();
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      instr_valid   = vecs[i].iv;
      mem_conflict  = vecs[i].mc;
      stall         = vecs[i].st;
      branch_taken  = vecs[i].br;
      instr_in      = vecs[i].instr;
      branch_target = vecs[i].tgt;
      e.row = i; e.e_instr = vecs[i].e_instr; e.e_pc = vecs[i].e_pc;
      e.e_valid = vecs[i].e_valid; e.e_pcout = vecs[i].e_pcout; e.e_hold = vecs[i].e_hold;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard row %0d: got empty queue want entry", i);
      end else begin
        e = exp_q.pop_front();
        chk("ifid_instr", e.row, ifid_instr, e.e_instr);
        chk("ifid_valid", e.row, 16'(ifid_valid), 16'(e.e_valid));
        chk("pc_out", e.row, pc_out, e.e_pcout);
        chk("fetch_hold", e.row, 16'(fetch_hold), 16'(e.e_hold));
        if (e.e_valid) chk("ifid_pc", e.row, ifid_pc, e.e_pc);
      end
    end
    vecs.delete();
  endtask

  initial begin
`ifndef BRANCH_DELAY_SLOT_EN
    //  rst iv mc st br instr     tgt        exp_instr exp_pc    v     pc_out    hold
    add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b0);
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b0);
    add(0, 1, 0, 0, 0, 16'h4801, 16'h0000, 16'h4801, 16'h0000, 1'b1, 16'h0001, 1'b0);
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0001, 1'b0);
    add(0, 1, 0, 0, 0, 16'h4802, 16'h0000, 16'h4802, 16'h0001, 1'b1, 16'h0002, 1'b0);
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0002, 1'b0);
    add(0, 1, 0, 0, 0, 16'h4803, 16'h0000, 16'h4803, 16'h0002, 1'b1, 16'h0003, 1'b0);
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0003, 1'b0);
    add(0, 1, 0, 0, 0, 16'h1234, 16'h0000, 16'h1234, 16'h0003, 1'b1, 16'h0004, 1'b0);
    add(0, 1, 0, 0, 0, 16'h1235, 16'h0000, 16'h1235, 16'h0004, 1'b1, 16'h0005, 1'b0);
    // six stall cycles; A000 from pc 5 parks in the skid buffer
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h1235, 16'h0004, 1'b1, 16'h0005, 1'b0);
    add(0, 1, 0, 1, 0, 16'hA000, 16'h0000, 16'h1235, 16'h0004, 1'b1, 16'h0006, 1'b1);
    add(0, 1, 0, 1, 0, 16'hBEEF, 16'h0000, 16'h1235, 16'h0004, 1'b1, 16'h0006, 1'b1);
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h1235, 16'h0004, 1'b1, 16'h0006, 1'b1);
    add(0, 1, 0, 1, 0, 16'hBEEF, 16'h0000, 16'h1235, 16'h0004, 1'b1, 16'h0006, 1'b1);
    add(0, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h1235, 16'h0004, 1'b1, 16'h0006, 1'b1);
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'hA000, 16'h0005, 1'b1, 16'h0006, 1'b0);
    add(0, 1, 0, 0, 0, 16'h6006, 16'h0000, 16'h6006, 16'h0006, 1'b1, 16'h0007, 1'b0);
    add(0, 1, 0, 0, 0, 16'h7007, 16'h0000, 16'h7007, 16'h0007, 1'b1, 16'h0008, 1'b0);
    // memory conflict at pc 8, then retry
    add(0, 1, 1, 0, 0, 16'hDEAD, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0008, 1'b0);
    add(0, 1, 0, 0, 0, 16'h8008, 16'h0000, 16'h8008, 16'h0008, 1'b1, 16'h0009, 1'b0);
    add(0, 1, 0, 0, 0, 16'h9009, 16'h0000, 16'h9009, 16'h0009, 1'b1, 16'h000A, 1'b0);
    // branch while pc 10 is in flight; returning word squashed
    add(0, 0, 0, 0, 1, 16'h0000, 16'h0040, 16'h0800, 16'h0000, 1'b0, 16'h0040, 1'b0);
    add(0, 1, 0, 0, 0, 16'hDEAD, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0040, 1'b0);
    add(0, 1, 0, 0, 0, 16'h4040, 16'h0000, 16'h4040, 16'h0040, 1'b1, 16'h0041, 1'b0);
    // branch beats stall and flushes a full skid; same-edge word so no squash
    add(0, 1, 0, 1, 0, 16'h4141, 16'h0000, 16'h4040, 16'h0040, 1'b1, 16'h0042, 1'b1);
    add(0, 1, 0, 1, 1, 16'h4242, 16'h0080, 16'h0800, 16'h0000, 1'b0, 16'h0080, 1'b0);
    add(0, 1, 0, 0, 0, 16'h8080, 16'h0000, 16'h8080, 16'h0080, 1'b1, 16'h0081, 1'b0);
    // drain and accept on the same edge
    add(0, 1, 0, 1, 0, 16'h8181, 16'h0000, 16'h8080, 16'h0080, 1'b1, 16'h0082, 1'b1);
    add(0, 1, 0, 0, 0, 16'h8282, 16'h0000, 16'h8181, 16'h0081, 1'b1, 16'h0083, 1'b1);
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h8282, 16'h0082, 1'b1, 16'h0083, 1'b0);
    add(0, 1, 1, 1, 0, 16'h1313, 16'h0000, 16'h8282, 16'h0082, 1'b1, 16'h0083, 1'b0);
    // PC wrap at FFFF
    add(0, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 16'h0800, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
    add(0, 1, 0, 0, 0, 16'h0BAD, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'hFFFF, 1'b0);
    add(0, 1, 0, 0, 0, 16'hF00F, 16'h0000, 16'hF00F, 16'hFFFF, 1'b1, 16'h0000, 1'b0);
    // reset while FULL must empty the skid buffer
    add(0, 1, 0, 1, 0, 16'h0A0A, 16'h0000, 16'hF00F, 16'hFFFF, 1'b1, 16'h0001, 1'b1);
    add(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b0);
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b0);
    add(0, 1, 0, 0, 0, 16'h1111, 16'h0000, 16'h1111, 16'h0000, 1'b1, 16'h0001, 1'b0);
    run_vectors();
`else
    add(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 20; i++)
      add(0, 1, 0, 0, 0, 16'(16'h5000 + i), 16'h0000, 16'(16'h5000 + i), 16'(i), 1'b1,
          16'(i + 1), 1'b0);
    run_vectors();
    // branch at pc 20, delay slot at pc 21, then redirect
    add(0, 1, 0, 0, 0, 16'hB020, 16'h0000, 16'hB020, 16'h0014, 1'b1, 16'h0015, 1'b0);
    add(0, 0, 0, 0, 1, 16'h0000, 16'h0100, 16'h0800, 16'h0000, 1'b0, 16'h0015, 1'b0);
    add(0, 1, 0, 0, 0, 16'hD021, 16'h0000, 16'hD021, 16'h0015, 1'b1, 16'h0100, 1'b0);
    add(0, 1, 0, 0, 0, 16'hC100, 16'h0000, 16'hC100, 16'h0100, 1'b1, 16'h0101, 1'b0);
    // delay-slot fetch lost to a conflict is retried before redirecting
    add(0, 1, 0, 0, 0, 16'hC101, 16'h0000, 16'hC101, 16'h0101, 1'b1, 16'h0102, 1'b0);
    add(0, 0, 0, 0, 1, 16'h0000, 16'h0200, 16'h0800, 16'h0000, 1'b0, 16'h0102, 1'b0);
    add(0, 1, 1, 0, 0, 16'hDEAD, 16'h0000, 16'h0800, 16'h0000, 1'b0, 16'h0102, 1'b0);
    add(0, 1, 0, 0, 0, 16'hD102, 16'h0000, 16'hD102, 16'h0102, 1'b1, 16'h0200, 1'b0);
    run_vectors();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the memory controller.
- Owns the PC and drives it to the memory controller's `pc` input.
- Consumes the returned instruction word, the fetch-complete strobe and the memory-conflict flag.
- Produces the IF/ID pipeline register for decode, including stall buffering, branch redirect and structural-hazard (MemConflict) retry.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_WORD, 16'h0800, encoding inserted into IF/ID for bubbles; matches the controller's NOP.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_out  output  16  fetch address to memory controller `pc`.
- instr_in  input  16  instruction word from memory controller.
- instr_valid  input  1  one-cycle strobe: instr_in/mem_conflict are the result of the fetch of the pc_out sampled at fetch start.
- mem_conflict  input  1  fetch slot taken by a data access; qualified by instr_valid.
- stall  input  1  hazard unit hold request for IF/ID.
- branch_taken  input  1  one-cycle redirect request from ID/EX.
- branch_target  input  16  redirect address, valid with branch_taken.
- ifid_instr  output  16  IF/ID instruction.
- ifid_pc  output  16  address of ifid_instr.
- ifid_valid  output  1  ifid_instr is a real instruction, not a bubble.
- fetch_hold  output  1  skid buffer full; the memory controller keeps refetching the same pc.

Behaviour:
- Reset (rst=1 at clk edge; takes effect at any time, including mid-fetch):
  - pc_out=RESET_PC, ifid_instr=NOP_WORD, ifid_pc=0, ifid_valid=0, fetch_hold=0.
  - Skid buffer empty, squash flag 0, pending-redirect flag 0.
- State machine on the skid buffer: EMPTY, FULL. Independent squash flag.
- Per-edge priority: rst > branch_taken > stall > instr_valid handling.
- Accept (instr_valid=1, mem_conflict=0, squash=0):
  - EMPTY, stall=0: IF/ID <= {instr_in, pc_out, valid=1}; pc_out <= pc_out+1.
  - EMPTY, stall=1: skid <= {instr_in, pc_out}; pc_out <= pc_out+1; go to FULL; IF/ID held.
  - FULL, stall=1: incoming word ignored; pc_out held (refetch).
- Drain: in FULL with stall=0, IF/ID <= skid, go to EMPTY.
  - A word accepted in the same cycle as the drain goes to skid; stays FULL.
- Stall with nothing to drain: IF/ID holds its value unchanged (valid included).
- mem_conflict=1 with instr_valid=1:
  - Fetch lost; pc_out held.
  - If stall=0 and EMPTY: IF/ID <= NOP_WORD, ifid_valid=0.
- instr_valid=0 with stall=0 and EMPTY: IF/ID <= NOP_WORD, valid=0 (bubble).
- branch_taken (macro absent):
  - pc_out <= branch_target; IF/ID <= NOP_WORD, valid=0; skid emptied.
  - If the edge does not carry instr_valid, set squash=1.
  - Next instr_valid clears squash and is discarded; pc_out is not advanced.
  - branch_taken together with stall: branch wins.
- PC arithmetic: 16-bit modulo; 16'hFFFF+1 = 16'h0000.
- fetch_hold = (state==FULL), registered.
- Latency: instruction appears in IF/ID on the edge of its instr_valid when unstalled.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined:
  - On branch_taken, IF/ID and skid are not flushed; no squash flag is set.
  - branch_target is latched with pending=1.
  - The next accepted instruction (the delay slot, at pc_out) enters normally.
  - On that same acceptance edge, pc_out <= latched target instead of pc_out+1; pending clears.
  - If the delay-slot fetch is lost to mem_conflict, pending stays set and the slot is retried.
  - A second branch_taken while pending=1 overwrites the target.
- Undefined: flush/squash behaviour as in Behaviour.

Test Plan:
- Reset then 3 clean fetches (instr_valid each 2 cycles, words 16'h4801/4802/4803):
  - IF/ID shows each word with pc 0,1,2; pc_out ends 3.
  - Bubbles (valid=0, 16'h0800) in between.
- stall=1 for 6 cycles while word 16'hA000 at pc 5 arrives:
  - fetch_hold=1, pc_out=6 frozen, IF/ID unchanged.
  - On release, IF/ID={A000, pc 5}, next fetch from 6.
- mem_conflict=1 with instr_valid at pc 8:
  - IF/ID bubble, pc_out stays 8.
  - Following clean fetch delivers pc 8.
- branch_taken target 16'h0040 mid-fetch at pc 10 (macro off):
  - IF/ID bubble, returning pc-10 word discarded.
  - Next valid instruction has pc 16'h0040.
- pc_out=16'hFFFF clean fetch:
  - ifid_pc=16'hFFFF, pc_out wraps to 16'h0000.
  - rst asserted while FULL empties the skid and restores pc_out=RESET_PC.
- Macro on, branch at pc 20 target 16'h0100:
  - Instruction at pc 21 enters IF/ID valid.
  - Then pc_out=16'h0100.
